// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two requester ports (A and B), the busy flag
// and the command/read-data link to the 256x8 command RAM.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and keeps
// it high until ack_x is seen. ack_x is a single-cycle pulse. rdata_x and
// err_x are valid in the ack cycle, and rdata_x is held until the next ack to
// that port. On the RAM side, ram_rx_valid qualifies ram_din for exactly one
// cycle per command word, and ram_tx_valid qualifies ram_dout.
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the RAM command link)
//   master - the environment (requesters plus RAM)
interface ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req_a;
  logic                 req_b;
  logic                 we_a;
  logic                 we_b;
  logic [ADDR_SIZE-1:0] addr_a;
  logic [ADDR_SIZE-1:0] addr_b;
  logic [ADDR_SIZE-1:0] wdata_a;
  logic [ADDR_SIZE-1:0] wdata_b;
  logic                 ack_a;
  logic                 ack_b;
  logic [ADDR_SIZE-1:0] rdata_a;
  logic [ADDR_SIZE-1:0] rdata_b;
  logic                 err_a;
  logic                 err_b;
  logic                 busy;
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  ram_dout, ram_tx_valid,
    output ack_a, ack_b, rdata_a, rdata_b, err_a, err_b, busy,
    output ram_din, ram_rx_valid
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output ram_dout, ram_tx_valid,
    input  ack_a, ack_b, rdata_a, rdata_b, err_a, err_b, busy,
    input  ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and command sequencer for the
// 256x8 single-port command RAM. Each granted transaction is turned into the
// RAM's two-beat command sequence; reads then wait (bounded by TIMEOUT) for
// ram_tx_valid and return the byte to the owner.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-high reset (RAM rst_n = ~rst at top level)
//   bus        - ram_arbiter_if.slave: requester A/B ports, busy, RAM link
//   dbg_state  - current FSM state encoding (IDLE=0, CMD1, CMD2, WAIT, DONE)
//
// Every output is a register; the combinational process computes the next
// value of every register, so outputs for a state appear in that state's cycle.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            rst,
  ram_arbiter_if.slave    bus,
  output logic [2:0]      dbg_state
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD1 = 3'd1,
    CMD2 = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;    // 0 = A, 1 = B
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic                 prio_b_q, prio_b_d;  // 1 = B wins a tie
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cnt_inc;
  logic [ADDR_SIZE+1:0] din_q, din_d;
  logic                 rxv_q, rxv_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic [ADDR_SIZE-1:0] rdata_a_q, rdata_a_d;
  logic [ADDR_SIZE-1:0] rdata_b_q, rdata_b_d;
  logic                 err_a_q, err_a_d;
  logic                 err_b_q, err_b_d;
  logic                 busy_q, busy_d;
  logic                 pick_b;

  assign cnt_inc = cnt_q + CW'(1);
  assign pick_b  = bus.req_b & (~bus.req_a | prio_b_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prio_b_d  = prio_b_q;
    cnt_d     = cnt_q;
    din_d     = '0;
    rxv_d     = 1'b0;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    err_a_d   = err_a_q;
    err_b_d   = err_b_q;

    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          owner_d  = pick_b;
          we_d     = pick_b ? bus.we_b    : bus.we_a;
          addr_d   = pick_b ? bus.addr_b  : bus.addr_a;
          wdata_d  = pick_b ? bus.wdata_b : bus.wdata_a;
          // The requester not served now wins the next tie.
          prio_b_d = ~pick_b;
          state_d  = CMD1;
          rxv_d    = 1'b1;
          din_d    = {(we_d ? 2'b00 : 2'b10), addr_d};
        end
      end
      CMD1: begin
        state_d = CMD2;
        rxv_d   = 1'b1;
        din_d   = we_q ? {2'b01, wdata_q} : {2'b11, {ADDR_SIZE{1'b0}}};
      end
      CMD2: begin
        if (we_q) begin
          state_d = DONE;
          if (owner_q) begin
            ack_b_d = 1'b1;
            err_b_d = 1'b0;
          end else begin
            ack_a_d = 1'b1;
            err_a_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // The read-address command cleared the RAM's sticky tx_valid, so any
        // tx_valid seen here belongs to this read.
        if (bus.ram_tx_valid) begin
          state_d = DONE;
          if (owner_q) begin
            ack_b_d   = 1'b1;
            rdata_b_d = bus.ram_dout;
            err_b_d   = 1'b0;
          end else begin
            ack_a_d   = 1'b1;
            rdata_a_d = bus.ram_dout;
            err_a_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_d = DONE;
            if (owner_q) begin
              ack_b_d   = 1'b1;
              rdata_b_d = '0;
              err_b_d   = 1'b1;
            end else begin
              ack_a_d   = 1'b1;
              rdata_a_d = '0;
              err_a_d   = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prio_b_q  <= 1'b0;
      cnt_q     <= '0;
      din_q     <= '0;
      rxv_q     <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prio_b_q  <= prio_b_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      rxv_q     <= rxv_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rxv_q;
  assign bus.ack_a        = ack_a_q;
  assign bus.ack_b        = ack_b_q;
  assign bus.rdata_a      = rdata_a_q;
  assign bus.rdata_b      = rdata_b_q;
  assign bus.err_a        = err_a_q;
  assign bus.err_b        = err_b_q;
  assign bus.busy         = busy_q;
  assign dbg_state        = state_q;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and command sequencer for the 256x8 single-port command RAM. It takes whole-byte read and write transactions from two requesters (A and B). Each transaction becomes the RAM's two-beat 10-bit command sequence on din/rx_valid; read data comes back on dout/tx_valid. The block sits between on-chip masters and the RAM, in place of the SPI slave, or alongside it behind an upstream mux.

## Interface
- ADDR_SIZE, 8: RAM address and data width.
- TIMEOUT, 15: maximum cycles spent in WAIT for ram_tx_valid before a read is aborted (1..255).
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset. The RAM's rst_n is driven as ~rst at the top level.
- req_a / req_b  in  1  transaction request, level, sampled only in IDLE.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  ADDR_SIZE  byte address.
- wdata_a / wdata_b  in  ADDR_SIZE  write data.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata_a / rdata_b  out  ADDR_SIZE  read data, valid with ack, held until the next ack to that port.
- err_a / err_b  out  1  read timeout flag, valid with ack.
- busy  out  1  high in every state except IDLE.
- ram_din  out  ADDR_SIZE+2  command word to the RAM: {opcode[1:0], payload}.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read-data valid (sticky in the RAM; cleared by any non-read command).

## Operation
- FSM states: IDLE, CMD1, CMD2, WAIT, DONE. All outputs are registered.
- IDLE:
  - If either req is high, grant one requester.
  - Latch its we/addr/wdata and the owner ID.
  - Go to CMD1.
- Arbitration:
  - If only one req is high, grant that requester.
  - If both are high, grant the requester that was not granted last.
  - The priority pointer resets to favour A.
- CMD1: ram_rx_valid=1.
  - Write: ram_din={2'b00, addr}.
  - Read: ram_din={2'b10, addr}.
  - Go to CMD2.
- CMD2: ram_rx_valid=1.
  - Write: ram_din={2'b01, wdata}, then go to DONE.
  - Read: ram_din={2'b11, 8'h00}, then go to WAIT.
- WAIT: ram_rx_valid=0.
  - If ram_tx_valid=1, capture ram_dout into the owner's rdata, clear the owner's err, go to DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set the owner's err=1, force rdata to 0, go to DONE.
- DONE: pulse the owner's ack for one cycle; the other ack stays 0. Return to IDLE.
- Writes clear the owner's err at DONE.
- A req still high in the IDLE cycle after ack starts a new transaction. Requesters drop req at the ack edge.
- Request fields are captured only at grant. Changes to them mid-transaction have no effect.
- ram_din and ram_rx_valid are 0 whenever the controller is not in CMD1 or CMD2.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and clears on entry to WAIT.

## Timing
- Reset values: ram_din=0, ram_rx_valid=0, ack_a=ack_b=0, rdata_a=rdata_b=0, err_a=err_b=0, busy=0. State is IDLE and the pointer favours A.
- Write: req sampled in cycle 0; cycle 1 carries {00,addr}, cycle 2 carries {01,wdata}, cycle 3 pulses ack. 4 cycles from IDLE back to IDLE.
- Read: req sampled in cycle 0; cycle 1 carries {10,addr}, cycle 2 carries {11,00}.
  - The {10,addr} command clears the RAM's sticky tx_valid, so ram_tx_valid=1 in cycle 3 reflects this read only.
  - rdata is captured at the end of cycle 3, ack pulses in cycle 4.
- Read nominal latency: 5 cycles from IDLE back to IDLE.
- Read timeout: ack in cycle TIMEOUT+3.
- busy is high from cycle 1 through the ack cycle.
- With both requesters continuously requesting, grants alternate A, B, A, B, ...
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - No ack is issued for the aborted transaction.
  - A half-issued command is not completed.

## Test plan
- After reset, write A addr=0x3C data=0xA5 → ram_din 0x03C then 0x1A5 with rx_valid in cycles 1-2; ack_a in cycle 3; busy high in cycles 1-3.
- B reads addr=0x3C after that write → ram_din 0x23C then 0x300; ack_b in cycle 4 with rdata_b=0xA5 and err_b=0.
- req_a and req_b asserted together and held for 4 transactions → grant order A, B, A, B. Exactly one ack per transaction, on the owner's port only.
- Read with ram_tx_valid held 0 (RAM stubbed) and TIMEOUT=15 → ack in cycle 18 with err=1 and rdata=0x00. A following normal read clears err.
- rst pulsed during CMD2 of a write → all outputs 0 next cycle, no ack issued. A fresh request afterwards completes normally.
- Two back-to-back reads of different addresses from A → each ack returns its own byte; no stale tx_valid from the first read is accepted.
